// File: rtl/reset_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_RELEASE  = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_STEP     = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERROR    = 3'd5
  } seq_state_t;

  // Domain index width; never narrower than one bit.
  function automatic int unsigned calc_idxw(input int unsigned n);
    if (n <= 32'd2) return 32'd1;
    return 32'($clog2(n));
  endfunction

  // Counter width wide enough to hold the largest terminal count.
  function automatic int unsigned calc_cw(input int unsigned hold_c,
                                          input int unsigned step_c,
                                          input int unsigned ack_c);
    int unsigned m;
    m = hold_c;
    if (step_c > m) m = step_c;
    if (ack_c > m) m = ack_c;
    return 32'($clog2(m + 32'd1));
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Two-stage reset synchroniser: asserts asynchronously, deasserts on the clock.
module reset_sync (
  input  logic clk,
  input  logic rst_n,
  output logic o_rst_sync_n
);

  logic [1:0] r_sync;

  // Shift ones in after reset release; clear both stages immediately on assertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], 1'b1};
    end
  end

  assign o_rst_sync_n = r_sync[1];

endmodule

// File: rtl/reset_sequencer.sv
// Releases reset domains one at a time in index order, waiting for each ack.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned  NUM_DOMAINS = 3,
  parameter int unsigned  HOLD_CYCLES = 16,
  parameter int unsigned  STEP_CYCLES = 8,
  parameter int unsigned  ACK_TIMEOUT = 255,
  localparam int unsigned IDXW        = calc_idxw(NUM_DOMAINS)
) (
  input  logic                   clk,
  input  logic                   async_reset_i,
  input  logic                   sw_reset_req_i,
  input  logic [NUM_DOMAINS-1:0] domain_ack_i,
  output logic [NUM_DOMAINS-1:0] domain_reset_o,
  output logic                   seq_done_o,
  output logic                   seq_error_o,
  output logic [IDXW-1:0]        err_domain_o
);

  localparam int unsigned CW = calc_cw(HOLD_CYCLES, STEP_CYCLES, ACK_TIMEOUT);

  localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_CYCLES - 32'd1);
  localparam logic [CW-1:0]   STEP_LAST = (STEP_CYCLES == 32'd0) ? '0 : CW'(STEP_CYCLES - 32'd1);
  localparam logic [CW-1:0]   ACK_LAST  = (ACK_TIMEOUT == 32'd0) ? '0 : CW'(ACK_TIMEOUT - 32'd1);
  localparam logic [CW-1:0]   CNT_MAX   = {CW{1'b1}};
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NUM_DOMAINS - 32'd1);
  localparam logic [NUM_DOMAINS-1:0] ALL_RESET = {NUM_DOMAINS{1'b1}};

  logic                   w_rst_n;

  seq_state_t             r_state;
  seq_state_t             w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic [CW-1:0]          w_cnt_inc;
  logic [IDXW-1:0]        r_idx;
  logic [IDXW-1:0]        w_idx_nxt;

  logic [NUM_DOMAINS-1:0] r_domain_reset;
  logic [NUM_DOMAINS-1:0] w_domain_reset_nxt;
  logic                   r_seq_done;
  logic                   w_seq_done_nxt;
  logic                   r_seq_error;
  logic                   w_seq_error_nxt;
  logic [IDXW-1:0]        r_err_domain;
  logic [IDXW-1:0]        w_err_domain_nxt;

  logic                   w_ack_cur;
  logic                   w_release;

  reset_sync u_reset_sync (
    .clk          (clk),
    .rst_n        (async_reset_i),
    .o_rst_sync_n (w_rst_n)
  );

  // Ack of the domain currently being brought up.
  always_comb begin
    w_ack_cur = 1'b0;
    for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
      if (r_idx == IDXW'(i)) w_ack_cur = domain_ack_i[i];
    end
  end

  // Shared cycle counter saturates instead of wrapping.
  always_comb begin
    w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
  end

  // Next-state, counter, index and output-register values.
  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = w_cnt_inc;
    w_idx_nxt          = r_idx;
    w_domain_reset_nxt = r_domain_reset;
    w_seq_done_nxt     = r_seq_done;
    w_seq_error_nxt    = r_seq_error;
    w_err_domain_nxt   = r_err_domain;
    w_release          = 1'b0;

    if (sw_reset_req_i) begin
      w_state_nxt        = ST_HOLD;
      w_cnt_nxt          = '0;
      w_idx_nxt          = '0;
      w_domain_reset_nxt = ALL_RESET;
      w_seq_done_nxt     = 1'b0;
      w_seq_error_nxt    = 1'b0;
      w_err_domain_nxt   = '0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            w_state_nxt = ST_RELEASE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_release   = 1'b1;
          end
        end
        ST_RELEASE: begin
          w_state_nxt = ST_WAIT_ACK;
          w_cnt_nxt   = '0;
        end
        ST_WAIT_ACK: begin
          // An ack in the last permitted cycle beats the timeout.
          if (w_ack_cur) begin
            w_cnt_nxt = '0;
            if (r_idx == IDX_LAST) begin
              w_state_nxt    = ST_DONE;
              w_seq_done_nxt = 1'b1;
            end else if (STEP_CYCLES == 32'd0) begin
              w_state_nxt = ST_RELEASE;
              w_idx_nxt   = r_idx + IDXW'(1);
              w_release   = 1'b1;
            end else begin
              w_state_nxt = ST_STEP;
            end
          end else if ((ACK_TIMEOUT != 32'd0) && (r_cnt == ACK_LAST)) begin
            w_state_nxt        = ST_ERROR;
            w_cnt_nxt          = '0;
            w_domain_reset_nxt = ALL_RESET;
            w_seq_error_nxt    = 1'b1;
            w_err_domain_nxt   = r_idx;
          end
        end
        ST_STEP: begin
          if (r_cnt == STEP_LAST) begin
            w_state_nxt = ST_RELEASE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = r_idx + IDXW'(1);
            w_release   = 1'b1;
          end
        end
        ST_DONE, ST_ERROR: begin
        end
        default: begin
          w_state_nxt        = ST_HOLD;
          w_cnt_nxt          = '0;
          w_idx_nxt          = '0;
          w_domain_reset_nxt = ALL_RESET;
          w_seq_done_nxt     = 1'b0;
          w_seq_error_nxt    = 1'b0;
          w_err_domain_nxt   = '0;
        end
      endcase
    end

    if (w_release) begin
      for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
        if (w_idx_nxt == IDXW'(i)) w_domain_reset_nxt[i] = 1'b0;
      end
    end
  end

  // State, counter and index registers.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_HOLD;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Output registers; reset forces every domain into reset without a glitch.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_domain_reset <= ALL_RESET;
      r_seq_done     <= 1'b0;
      r_seq_error    <= 1'b0;
      r_err_domain   <= '0;
    end else begin
      r_domain_reset <= w_domain_reset_nxt;
      r_seq_done     <= w_seq_done_nxt;
      r_seq_error    <= w_seq_error_nxt;
      r_err_domain   <= w_err_domain_nxt;
    end
  end

  assign domain_reset_o = r_domain_reset;
  assign seq_done_o     = r_seq_done;
  assign seq_error_o    = r_seq_error;
  assign err_domain_o   = r_err_domain;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: 3-domain and 1-domain configurations.
module tb_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       sw;
  logic [2:0] ack;
  logic [2:0] dr;
  logic       done;
  logic       err;
  logic [1:0] errdom;

  logic       rst1_n;
  logic       sw1;
  logic [0:0] ack1;
  logic [0:0] dr1;
  logic       done1;
  logic       err1;
  logic [0:0] errdom1;

  int n_vec;
  int n_err;

  logic [4:0] exp5;
  logic [4:0] got5;

  reset_sequencer #(
    .NUM_DOMAINS (3),
    .HOLD_CYCLES (4),
    .STEP_CYCLES (2),
    .ACK_TIMEOUT (10)
  ) dut (
    .clk            (clk),
    .async_reset_i  (rst_n),
    .sw_reset_req_i (sw),
    .domain_ack_i   (ack),
    .domain_reset_o (dr),
    .seq_done_o     (done),
    .seq_error_o    (err),
    .err_domain_o   (errdom)
  );

  reset_sequencer #(
    .NUM_DOMAINS (1),
    .HOLD_CYCLES (4),
    .STEP_CYCLES (0),
    .ACK_TIMEOUT (10)
  ) dut1 (
    .clk            (clk),
    .async_reset_i  (rst1_n),
    .sw_reset_req_i (sw1),
    .domain_ack_i   (ack1),
    .domain_reset_o (dr1),
    .seq_done_o     (done1),
    .seq_error_o    (err1),
    .err_domain_o   (errdom1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected domain resets for a clean run whose first release is at edge f0.
  function automatic logic [2:0] exp_dr(input int e, input int f0);
    if (e < f0)          return 3'b111;
    else if (e < f0 + 4) return 3'b110;
    else if (e < f0 + 8) return 3'b100;
    else                 return 3'b000;
  endfunction

  task automatic test_reset;
    tick;
    n_vec++;
    if ({dr, done, err, errdom} !== 7'b111_0_0_00) begin
      n_err++;
      $display("FAIL reset_state got=%b exp=%b", {dr, done, err, errdom}, 7'b111_0_0_00);
    end
    n_vec++;
    if ({dr1, done1, err1, errdom1} !== 4'b1_0_0_0) begin
      n_err++;
      $display("FAIL reset_state_1dom got=%b exp=%b", {dr1, done1, err1, errdom1}, 4'b1000);
    end
  endtask

  task automatic test_normal;
    ack   = 3'b111;
    rst_n = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      tick;
      exp5 = {exp_dr(e, 6), (e >= 16), 1'b0};
      got5 = {dr, done, err};
      n_vec++;
      if (got5 !== exp5) begin
        n_err++;
        $display("FAIL normal e=%0d got=%b exp=%b", e, got5, exp5);
      end
    end
    ack = 3'b000;
    repeat (3) tick;
    n_vec++;
    if ({dr, done, err} !== 5'b000_1_0) begin
      n_err++;
      $display("FAIL done_ack_drop got=%b exp=%b", {dr, done, err}, 5'b00010);
    end
  endtask

  task automatic test_sw_in_done;
    ack = 3'b111;
    sw  = 1'b1;
    tick;
    sw = 1'b0;
    n_vec++;
    if ({dr, done, err, errdom} !== 7'b111_0_0_00) begin
      n_err++;
      $display("FAIL sw_done_clear got=%b exp=%b", {dr, done, err, errdom}, 7'b1110000);
    end
    for (int e = 1; e <= 16; e++) begin
      tick;
      exp5 = {exp_dr(e, 4), (e >= 14), 1'b0};
      got5 = {dr, done, err};
      n_vec++;
      if (got5 !== exp5) begin
        n_err++;
        $display("FAIL sw_done_seq e=%0d got=%b exp=%b", e, got5, exp5);
      end
    end
  endtask

  task automatic test_timeout;
    logic [2:0] xd;
    ack = 3'b101;
    sw  = 1'b1;
    tick;
    sw = 1'b0;
    for (int e = 1; e <= 19; e++) begin
      tick;
      if (e < 4)       xd = 3'b111;
      else if (e < 8)  xd = 3'b110;
      else if (e < 19) xd = 3'b100;
      else             xd = 3'b111;
      exp5 = {xd, 1'b0, (e >= 19)};
      got5 = {dr, done, err};
      n_vec++;
      if (got5 !== exp5) begin
        n_err++;
        $display("FAIL timeout e=%0d got=%b exp=%b", e, got5, exp5);
      end
    end
    n_vec++;
    if (errdom !== 2'd1) begin
      n_err++;
      $display("FAIL timeout_errdom got=%0d exp=1", errdom);
    end
    ack = 3'b111;
    repeat (3) tick;
    n_vec++;
    if ({dr, done, err, errdom} !== 7'b111_0_1_01) begin
      n_err++;
      $display("FAIL error_sticky got=%b exp=%b", {dr, done, err, errdom}, 7'b1110101);
    end
  endtask

  task automatic test_sw_in_error;
    ack = 3'b111;
    sw  = 1'b1;
    tick;
    sw = 1'b0;
    n_vec++;
    if ({dr, done, err, errdom} !== 7'b111_0_0_00) begin
      n_err++;
      $display("FAIL sw_error_clear got=%b exp=%b", {dr, done, err, errdom}, 7'b1110000);
    end
    for (int e = 1; e <= 16; e++) begin
      tick;
      exp5 = {exp_dr(e, 4), (e >= 14), 1'b0};
      got5 = {dr, done, err};
      n_vec++;
      if (got5 !== exp5) begin
        n_err++;
        $display("FAIL sw_error_seq e=%0d got=%b exp=%b", e, got5, exp5);
      end
    end
  endtask

  task automatic test_ack_last_cycle;
    logic [2:0] xd;
    ack = 3'b101;
    sw  = 1'b1;
    tick;
    sw = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      tick;
      if (e < 4)       xd = 3'b111;
      else if (e < 8)  xd = 3'b110;
      else if (e < 21) xd = 3'b100;
      else             xd = 3'b000;
      exp5 = {xd, (e >= 23), 1'b0};
      got5 = {dr, done, err};
      n_vec++;
      if (got5 !== exp5) begin
        n_err++;
        $display("FAIL ack_last_cycle e=%0d got=%b exp=%b", e, got5, exp5);
      end
      if (e == 18) ack = 3'b111;
    end
  endtask

  task automatic test_sw_with_ack;
    ack = 3'b000;
    sw  = 1'b1;
    tick;
    sw = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick;
      n_vec++;
      if (dr !== exp_dr(e, 4)) begin
        n_err++;
        $display("FAIL sw_ack_pre e=%0d got=%b exp=%b", e, dr, exp_dr(e, 4));
      end
    end
    ack = 3'b111;
    sw  = 1'b1;
    tick;
    sw = 1'b0;
    n_vec++;
    if ({dr, done, err} !== 5'b111_0_0) begin
      n_err++;
      $display("FAIL sw_ack_priority got=%b exp=%b", {dr, done, err}, 5'b11100);
    end
    for (int e = 1; e <= 16; e++) begin
      tick;
      exp5 = {exp_dr(e, 4), (e >= 14), 1'b0};
      got5 = {dr, done, err};
      n_vec++;
      if (got5 !== exp5) begin
        n_err++;
        $display("FAIL sw_ack_seq e=%0d got=%b exp=%b", e, got5, exp5);
      end
    end
  endtask

  task automatic test_async_mid_step;
    ack = 3'b111;
    sw  = 1'b1;
    tick;
    sw = 1'b0;
    for (int e = 1; e <= 6; e++) tick;
    n_vec++;
    if (dr !== 3'b110) begin
      n_err++;
      $display("FAIL async_pre_step got=%b exp=110", dr);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({dr, done, err, errdom} !== 7'b111_0_0_00) begin
      n_err++;
      $display("FAIL async_immediate got=%b exp=%b", {dr, done, err, errdom}, 7'b1110000);
    end
    #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      tick;
      exp5 = {exp_dr(e, 6), (e >= 16), 1'b0};
      got5 = {dr, done, err};
      n_vec++;
      if (got5 !== exp5) begin
        n_err++;
        $display("FAIL async_restart e=%0d got=%b exp=%b", e, got5, exp5);
      end
    end
  endtask

  task automatic test_single_domain;
    logic [2:0] g3;
    logic [2:0] x3;
    ack1   = 1'b0;
    rst1_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick;
      x3 = {(e < 6), (e >= 10), 1'b0};
      g3 = {dr1, done1, err1};
      n_vec++;
      if (g3 !== x3) begin
        n_err++;
        $display("FAIL single_domain e=%0d got=%b exp=%b", e, g3, x3);
      end
      if (e == 9) ack1 = 1'b1;
    end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    sw     = 1'b0;
    ack    = 3'b000;
    rst1_n = 1'b0;
    sw1    = 1'b0;
    ack1   = 1'b0;
    test_reset;
    test_normal;
    test_sw_in_done;
    test_timeout;
    test_sw_in_error;
    test_ack_last_cycle;
    test_sw_with_ack;
    test_async_mid_step;
    test_single_domain;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
